// File: rtl/ping_seq_pkg.sv
// Shared types and constants for the ping sequencer slice.
// Optional feature macro: OVERRUN_COUNT_EN (adds overrun_cnt to the bus).
package ping_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX,
        BLANK,
        LISTEN,
        DONE
    } seq_state_t;

    localparam int CLK_HZ         = 150_000_000;
    localparam int LEN_W_DEFAULT  = 20;
    localparam int NUM_CH_DEFAULT = 4;

endpackage

// File: rtl/ping_sequencer_if.sv
// Control/status bundle between the trigger side and the ping sequencer.
// The master drives trigger, enable, mask and phase lengths; the slave
// (the sequencer) drives the TX/RX gating and status pulses.
// Optional feature macro: OVERRUN_COUNT_EN adds the overrun_cnt status word.
interface ping_sequencer_if
    import ping_seq_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int LEN_W  = LEN_W_DEFAULT
);

    logic                      trigger_in;
    logic                      enable;
    logic [NUM_CH-1:0]         ch_mask;
    logic [LEN_W-1:0]          tx_len;
    logic [LEN_W-1:0]          blank_len;
    logic [LEN_W-1:0]          listen_len;

    logic                      tx_en;
    logic [$clog2(NUM_CH)-1:0] tx_chan;
    logic                      rx_en;
    logic                      busy;
    logic                      frame_done;
    logic                      overrun;
`ifdef OVERRUN_COUNT_EN
    logic [15:0]               overrun_cnt;
`endif

    modport master (
        output trigger_in,
        output enable,
        output ch_mask,
        output tx_len,
        output blank_len,
        output listen_len,
        input  tx_en,
        input  tx_chan,
        input  rx_en,
        input  busy,
        input  frame_done,
`ifdef OVERRUN_COUNT_EN
        input  overrun_cnt,
`endif
        input  overrun
    );

    modport slave (
        input  trigger_in,
        input  enable,
        input  ch_mask,
        input  tx_len,
        input  blank_len,
        input  listen_len,
        output tx_en,
        output tx_chan,
        output rx_en,
        output busy,
        output frame_done,
`ifdef OVERRUN_COUNT_EN
        output overrun_cnt,
`endif
        output overrun
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set mask bit strictly
// after the last-served index, wrapping at NUM_CH. The last-served channel
// itself is only chosen again when it is the only eligible one.
module rr_pick
    import ping_seq_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT
) (
    input  logic [NUM_CH-1:0]         mask_i,
    input  logic [$clog2(NUM_CH)-1:0] last_i,
    output logic                      valid_o,
    output logic [$clog2(NUM_CH)-1:0] idx_o
);

    localparam int IDX_W = $clog2(NUM_CH);

    // Scan from the farthest offset to the nearest so the nearest set bit wins
    always_comb begin
        int j;
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int off = NUM_CH; off >= 1; off--) begin
            j = int'(last_i) + off;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            if (mask_i[j]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/ping_sequencer.sv
// Ranging-frame sequencer: one TX burst, blanking gap and listen window per
// accepted trigger, round-robin across the eligible transmit channels.
// A single down-counter times whichever phase is active; zero-length phases
// are skipped entirely. All outputs are registered.
// Optional feature macro: OVERRUN_COUNT_EN adds a saturating overrun counter.
module ping_sequencer
    import ping_seq_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int LEN_W  = LEN_W_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    ping_sequencer_if.slave  bus
);

    localparam int                IDX_W      = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0]  LAST_RESET = IDX_W'(NUM_CH - 1);
    localparam logic [LEN_W-1:0]  LEN_ONE    = LEN_W'(1);

    seq_state_t        state_q, state_d;
    logic [LEN_W-1:0]  timer_q, timer_d;
    logic [LEN_W-1:0]  blankLen_q;
    logic [LEN_W-1:0]  listenLen_q;
    logic [IDX_W-1:0]  lastChan_q;
    logic [IDX_W-1:0]  txChan_q;
    logic              txEn_q;
    logic              rxEn_q;
    logic              busy_q;
    logic              frameDone_q;
    logic              overrun_q;

    logic              accept;
    logic              overrun_d;
    logic              pickValid;
    logic [IDX_W-1:0]  pickIdx;

    seq_state_t        startState, afterTx, afterBlank;
    logic [LEN_W-1:0]  startLoad, afterTxLoad, afterBlankLoad;

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rrPick (
        .mask_i  (bus.ch_mask),
        .last_i  (lastChan_q),
        .valid_o (pickValid),
        .idx_o   (pickIdx)
    );

    // Work out which phase follows each point, skipping zero-length phases
    always_comb begin
        startState = DONE;
        startLoad  = '0;
        if (bus.tx_len != '0) begin
            startState = TX;
            startLoad  = bus.tx_len - LEN_ONE;
        end else if (bus.blank_len != '0) begin
            startState = BLANK;
            startLoad  = bus.blank_len - LEN_ONE;
        end else if (bus.listen_len != '0) begin
            startState = LISTEN;
            startLoad  = bus.listen_len - LEN_ONE;
        end

        afterTx     = DONE;
        afterTxLoad = '0;
        if (blankLen_q != '0) begin
            afterTx     = BLANK;
            afterTxLoad = blankLen_q - LEN_ONE;
        end else if (listenLen_q != '0) begin
            afterTx     = LISTEN;
            afterTxLoad = listenLen_q - LEN_ONE;
        end

        afterBlank     = DONE;
        afterBlankLoad = '0;
        if (listenLen_q != '0) begin
            afterBlank     = LISTEN;
            afterBlankLoad = listenLen_q - LEN_ONE;
        end
    end

    // Next-state and phase-timer decisions for the frame FSM
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.trigger_in && bus.enable && pickValid) begin
                    accept  = 1'b1;
                    state_d = startState;
                    timer_d = startLoad;
                end
            end
            TX: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d = afterTx;
                    timer_d = afterTxLoad;
                end else begin
                    timer_d = timer_q - LEN_ONE;
                end
            end
            BLANK: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d = afterBlank;
                    timer_d = afterBlankLoad;
                end else begin
                    timer_d = timer_q - LEN_ONE;
                end
            end
            LISTEN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d = DONE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - LEN_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign overrun_d = bus.trigger_in && (state_q != IDLE);

    // Register state, latched frame parameters and the decoded outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            blankLen_q  <= '0;
            listenLen_q <= '0;
            lastChan_q  <= LAST_RESET;
            txChan_q    <= '0;
            txEn_q      <= 1'b0;
            rxEn_q      <= 1'b0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            txEn_q      <= (state_d == TX);
            rxEn_q      <= (state_d == LISTEN);
            busy_q      <= (state_d != IDLE);
            frameDone_q <= (state_d == DONE);
            overrun_q   <= overrun_d;
            if (accept) begin
                blankLen_q  <= bus.blank_len;
                listenLen_q <= bus.listen_len;
                lastChan_q  <= pickIdx;
                txChan_q    <= pickIdx;
            end
        end
    end

    assign bus.tx_en      = txEn_q;
    assign bus.tx_chan    = txChan_q;
    assign bus.rx_en      = rxEn_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frameDone_q;
    assign bus.overrun    = overrun_q;

`ifdef OVERRUN_COUNT_EN
    logic [15:0] overrunCnt_q;

    // Count dropped triggers, holding at all-ones rather than wrapping
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            overrunCnt_q <= '0;
        end else if (overrun_d && (overrunCnt_q != 16'hFFFF)) begin
            overrunCnt_q <= overrunCnt_q + 16'd1;
        end
    end

    assign bus.overrun_cnt = overrunCnt_q;
`endif

endmodule

// File: tb/tb_ping_sequencer.sv
// Directed bench for ping_sequencer: frame timing, round-robin order,
// overrun, zero-length phases, abort, empty mask and async reset.
module tb_ping_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int txCnt, rxCnt, firstTx, lastTx, firstRx, lastRx, doneAt, pulses;

    ping_sequencer_if #(.NUM_CH(4), .LEN_W(20)) seqBus ();

    ping_sequencer #(.NUM_CH(4), .LEN_W(20)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (seqBus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present frame parameters and pulse trigger for one cycle; returns in cycle t+1
    task automatic applyStimulus(input logic [3:0] mask, input logic [19:0] txL,
                                 input logic [19:0] blankL, input logic [19:0] listenL);
        seqBus.ch_mask    = mask;
        seqBus.tx_len     = txL;
        seqBus.blank_len  = blankL;
        seqBus.listen_len = listenL;
        seqBus.trigger_in = 1'b1;
        tick();
        seqBus.trigger_in = 1'b0;
    endtask

    // Walk a frame from cycle t+1 until frame_done (or the bound), recording phase edges
    task automatic measureFrame(input int limit, output int nTx, output int nRx,
                                output int fTx, output int lTx, output int fRx,
                                output int lRx, output int dAt);
        nTx = 0; nRx = 0; fTx = -1; lTx = -1; fRx = -1; lRx = -1; dAt = -1;
        for (int c = 1; c <= limit; c++) begin
            if (seqBus.tx_en) begin
                nTx++;
                if (fTx < 0) fTx = c;
                lTx = c;
            end
            if (seqBus.rx_en) begin
                nRx++;
                if (fRx < 0) fRx = c;
                lRx = c;
            end
            if (seqBus.frame_done) begin
                dAt = c;
                break;
            end
            tick();
        end
    endtask

    initial begin
        rst               = 1'b1;
        seqBus.trigger_in = 1'b0;
        seqBus.enable     = 1'b1;
        seqBus.ch_mask    = '0;
        seqBus.tx_len     = '0;
        seqBus.blank_len  = '0;
        seqBus.listen_len = '0;
        #12;
        checkOutput("reset_tx_en", seqBus.tx_en, 0);
        checkOutput("reset_rx_en", seqBus.rx_en, 0);
        checkOutput("reset_busy", seqBus.busy, 0);
        checkOutput("reset_tx_chan", seqBus.tx_chan, 0);
        checkOutput("reset_frame_done", seqBus.frame_done, 0);
        checkOutput("reset_overrun", seqBus.overrun, 0);
`ifdef OVERRUN_COUNT_EN
        checkOutput("reset_overrun_cnt", seqBus.overrun_cnt, 0);
`endif
        rst = 1'b0;
        tick();

        $display("[TB] full frame 30/150/3000");
        applyStimulus(4'b1111, 20'd30, 20'd150, 20'd3000);
        checkOutput("f1_tx_chan", seqBus.tx_chan, 0);
        checkOutput("f1_busy", seqBus.busy, 1);
        measureFrame(3300, txCnt, rxCnt, firstTx, lastTx, firstRx, lastRx, doneAt);
        checkOutput("f1_tx_count", txCnt, 30);
        checkOutput("f1_tx_first", firstTx, 1);
        checkOutput("f1_tx_last", lastTx, 30);
        checkOutput("f1_rx_count", rxCnt, 3000);
        checkOutput("f1_rx_first", firstRx, 181);
        checkOutput("f1_rx_last", lastRx, 3180);
        checkOutput("f1_done_at", doneAt, 3181);
        tick();
        checkOutput("f1_idle_busy", seqBus.busy, 0);
        checkOutput("f1_done_pulse_end", seqBus.frame_done, 0);

        $display("[TB] round robin over mask 1010");
        applyStimulus(4'b1010, 20'd2, 20'd1, 20'd2);
        checkOutput("rr0_chan", seqBus.tx_chan, 1);
        measureFrame(20, txCnt, rxCnt, firstTx, lastTx, firstRx, lastRx, doneAt);
        checkOutput("rr0_done_at", doneAt, 6);
        checkOutput("rr0_rx_first", firstRx, 4);
        tick();
        applyStimulus(4'b1010, 20'd2, 20'd1, 20'd2);
        checkOutput("rr1_chan", seqBus.tx_chan, 3);
        measureFrame(20, txCnt, rxCnt, firstTx, lastTx, firstRx, lastRx, doneAt);
        checkOutput("rr1_done_at", doneAt, 6);
        tick();
        applyStimulus(4'b1010, 20'd2, 20'd1, 20'd2);
        checkOutput("rr2_chan", seqBus.tx_chan, 1);
        measureFrame(20, txCnt, rxCnt, firstTx, lastTx, firstRx, lastRx, doneAt);
        checkOutput("rr2_done_at", doneAt, 6);
        tick();
        applyStimulus(4'b1010, 20'd2, 20'd1, 20'd2);
        checkOutput("rr3_chan", seqBus.tx_chan, 3);
        measureFrame(20, txCnt, rxCnt, firstTx, lastTx, firstRx, lastRx, doneAt);
        checkOutput("rr3_done_at", doneAt, 6);
        tick();

        $display("[TB] trigger during frame");
        applyStimulus(4'b1111, 20'd10, 20'd100, 20'd50);
        checkOutput("ov_chan", seqBus.tx_chan, 0);
        doneAt = -1;
        for (int c = 1; c <= 300; c++) begin
            if (c == 100) begin
                checkOutput("ov_before", seqBus.overrun, 0);
                seqBus.trigger_in = 1'b1;
            end
            if (c == 101) begin
                seqBus.trigger_in = 1'b0;
                checkOutput("ov_pulse", seqBus.overrun, 1);
            end
            if (c == 102) begin
                checkOutput("ov_pulse_end", seqBus.overrun, 0);
            end
            if (seqBus.frame_done) begin
                doneAt = c;
                break;
            end
            tick();
        end
        checkOutput("ov_done_at", doneAt, 161);
`ifdef OVERRUN_COUNT_EN
        checkOutput("ov_count", seqBus.overrun_cnt, 1);
`endif
        tick();

        $display("[TB] zero tx and blank, listen 5");
        applyStimulus(4'b1111, 20'd0, 20'd0, 20'd5);
        checkOutput("z_chan", seqBus.tx_chan, 1);
        measureFrame(20, txCnt, rxCnt, firstTx, lastTx, firstRx, lastRx, doneAt);
        checkOutput("z_tx_count", txCnt, 0);
        checkOutput("z_rx_first", firstRx, 1);
        checkOutput("z_rx_last", lastRx, 5);
        checkOutput("z_done_at", doneAt, 6);
        tick();

        $display("[TB] abort with enable low");
        applyStimulus(4'b1111, 20'd30, 20'd150, 20'd3000);
        checkOutput("ab_chan", seqBus.tx_chan, 2);
        for (int c = 1; c < 50; c++) tick();
        checkOutput("ab_busy_before", seqBus.busy, 1);
        seqBus.enable = 1'b0;
        tick();
        checkOutput("ab_tx_en", seqBus.tx_en, 0);
        checkOutput("ab_rx_en", seqBus.rx_en, 0);
        checkOutput("ab_busy", seqBus.busy, 0);
        seqBus.enable = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            if (seqBus.frame_done) pulses++;
            tick();
        end
        checkOutput("ab_no_frame_done", pulses, 0);

        $display("[TB] all phases zero");
        applyStimulus(4'b1111, 20'd0, 20'd0, 20'd0);
        checkOutput("e_chan", seqBus.tx_chan, 3);
        checkOutput("e_frame_done", seqBus.frame_done, 1);
        checkOutput("e_busy", seqBus.busy, 1);
        checkOutput("e_tx_en", seqBus.tx_en, 0);
        tick();
        checkOutput("e_idle", seqBus.busy, 0);

        $display("[TB] empty mask");
        applyStimulus(4'b0000, 20'd5, 20'd5, 20'd5);
        checkOutput("m0_busy", seqBus.busy, 0);
        checkOutput("m0_overrun", seqBus.overrun, 0);
        checkOutput("m0_chan", seqBus.tx_chan, 3);
        tick();

        $display("[TB] async reset mid-listen");
        applyStimulus(4'b0100, 20'd2, 20'd2, 20'd100);
        for (int c = 1; c < 10; c++) tick();
        checkOutput("rs_rx_before", seqBus.rx_en, 1);
        checkOutput("rs_chan_before", seqBus.tx_chan, 2);
        rst = 1'b1;
        #1;
        checkOutput("rs_rx_en", seqBus.rx_en, 0);
        checkOutput("rs_busy", seqBus.busy, 0);
        checkOutput("rs_tx_chan", seqBus.tx_chan, 0);
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(4'b1111, 20'd0, 20'd0, 20'd1);
        checkOutput("rs_post_chan", seqBus.tx_chan, 0);
        measureFrame(10, txCnt, rxCnt, firstTx, lastTx, firstRx, lastRx, doneAt);
        checkOutput("rs_post_done_at", doneAt, 2);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
